// File: rtl/sec_label_fifo_if.sv
// Handshake bundle for sec_label_fifo: enqueue side, dequeue side with
// reader clearance, scrub control and occupancy.
interface sec_label_fifo_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 1
);
  logic                       enq_valid;
  logic                       enq_ready;
  logic [DATA_W-1:0]          enq_data;
  logic [LVL_W-1:0]           enq_lvl;
  logic [LVL_W-1:0]           rd_lvl;
  logic                       deq_valid;
  logic                       deq_ready;
  logic [DATA_W-1:0]          deq_data;
  logic [LVL_W-1:0]           deq_lvl;
  logic                       deq_blocked;
  logic                       scrub_req;
  logic [LVL_W-1:0]           scrub_lvl;
  logic                       scrub_busy;
  logic                       scrub_done;
  logic [$clog2(DEPTH):0]     count;

  // Producer, consumer and scrub controller view.
  modport master (
    output enq_valid, enq_data, enq_lvl, rd_lvl, deq_ready, scrub_req, scrub_lvl,
    input  enq_ready, deq_valid, deq_data, deq_lvl, deq_blocked,
           scrub_busy, scrub_done, count
  );

  // FIFO view.
  modport slave (
    input  enq_valid, enq_data, enq_lvl, rd_lvl, deq_ready, scrub_req, scrub_lvl,
    output enq_ready, deq_valid, deq_data, deq_lvl, deq_blocked,
           scrub_busy, scrub_done, count
  );
endinterface

// File: rtl/sec_label_fifo.sv
// Security-labelled FIFO: each entry carries a level tag, the head is only
// released when its tag is within the reader clearance, and a scrub engine
// zeroes then downgrades every slot tagged above a requested level.
module sec_label_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = 1
) (
  input  logic                clk,
  input  logic                reset,
  sec_label_fifo_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_q, rd_q, idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LVL_W-1:0]  slvl_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [LVL_W-1:0]  lvl_q  [DEPTH];

  logic              idle, empty, full, head_ok, enq_fire, deq_fire;
  logic [LVL_W-1:0]  head_lvl;

  // Output side: everything here is combinational from registered state,
  // so a change of rd_lvl is reflected in the same cycle.
  always_comb begin
    idle     = (state_q == S_IDLE);
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNT_W'(DEPTH));
    head_lvl = lvl_q[rd_q];
    head_ok  = (head_lvl <= bus.rd_lvl);

    bus.enq_ready   = !full && idle;
    bus.deq_valid   = !empty && idle && head_ok;
    bus.deq_blocked = !empty && idle && !head_ok;
    // Data above clearance must never leak onto the output pins.
    bus.deq_data    = bus.deq_valid ? data_q[rd_q] : '0;
    bus.deq_lvl     = bus.deq_valid ? head_lvl     : '0;
    bus.count       = cnt_q;

    enq_fire = bus.enq_valid && bus.enq_ready;
    deq_fire = bus.deq_valid && bus.deq_ready;
  end

  // Scrub FSM next state and status outputs.
  always_comb begin
    state_d        = state_q;
    bus.scrub_busy = 1'b0;
    bus.scrub_done = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.scrub_req) state_d = S_SCAN;
      S_SCAN: begin
        bus.scrub_busy = 1'b1;
        if (idx_q == PTR_W'(DEPTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        bus.scrub_busy = 1'b1;
        bus.scrub_done = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, pointers, occupancy and storage (queue writes and scrub
  // writes are mutually exclusive since enqueue is closed during a scan).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      slvl_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        lvl_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;

      if (enq_fire) begin
        data_q[wr_q] <= bus.enq_data;
        lvl_q[wr_q]  <= bus.enq_lvl;
        wr_q         <= wr_q + 1'b1;
      end
      if (deq_fire) rd_q <= rd_q + 1'b1;

      case ({enq_fire, deq_fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (idle && bus.scrub_req) begin
        slvl_q <= bus.scrub_lvl;
        idx_q  <= '0;
      end

      // Every physical slot is visited, occupied or not; erase before downgrade.
      if (state_q == S_SCAN) begin
        if (lvl_q[idx_q] > slvl_q) begin
          data_q[idx_q] <= '0;
          lvl_q[idx_q]  <= slvl_q;
        end
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sec_label_fifo.sv
// Directed bench for sec_label_fifo at DATA_W=4, DEPTH=4, LVL_W=1.
module tb_sec_label_fifo;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sec_label_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) bus ();

  sec_label_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enq_valid = 1'b0;
    bus.enq_data  = '0;
    bus.enq_lvl   = '0;
    bus.rd_lvl    = '0;
    bus.deq_ready = 1'b0;
    bus.scrub_req = 1'b0;
    bus.scrub_lvl = '0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    // {enq_ready, deq_valid, deq_blocked, busy, done, count[2:0]}
    got = {bus.enq_ready, bus.deq_valid, bus.deq_blocked, bus.scrub_busy,
           bus.scrub_done, bus.count};
    checks++;
    if (got !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_status got %b exp %b", got, 8'b1000_0000);
    end
    checks++;
    if ({bus.deq_data, bus.deq_lvl} !== 5'd0) begin
      errors++;
      $display("FAIL reset_deq_out got %h exp 0", {bus.deq_data, bus.deq_lvl});
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_data  = 4'(i + 1);
      bus.enq_lvl   = 1'b0;
      step();
    end
    bus.enq_valid = 1'b0;
    #1;
    checks++;
    if ({bus.count, bus.enq_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full count=%0d enq_ready=%b exp 4/0", bus.count, bus.enq_ready);
    end
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.deq_valid, bus.deq_data} !== {1'b1, 4'(i + 1)}) begin
        errors++;
        $display("FAIL drain%0d valid=%b data=%0d exp 1/%0d", i, bus.deq_valid,
                 bus.deq_data, i + 1);
      end
      step();
    end
    bus.deq_ready = 1'b0;
    #1;
    checks++;
    if ({bus.count, bus.deq_valid} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL drained count=%0d deq_valid=%b exp 0/0", bus.count, bus.deq_valid);
    end
  endtask

  task automatic test_blocked_head();
    bus.rd_lvl    = 1'b0;
    bus.enq_valid = 1'b1;
    bus.enq_data  = 4'd9;
    bus.enq_lvl   = 1'b1;
    step();
    bus.enq_data  = 4'd5;
    bus.enq_lvl   = 1'b0;
    step();
    bus.enq_valid = 1'b0;
    #1;
    checks++;
    if ({bus.deq_valid, bus.deq_blocked, bus.deq_data, bus.deq_lvl, bus.count} !==
        {1'b0, 1'b1, 4'd0, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL blocked v=%b b=%b d=%0d l=%b cnt=%0d exp 0 1 0 0 2", bus.deq_valid,
               bus.deq_blocked, bus.deq_data, bus.deq_lvl, bus.count);
    end
    bus.rd_lvl = 1'b1;
    #1;
    checks++;
    if ({bus.deq_valid, bus.deq_blocked, bus.deq_data, bus.deq_lvl} !==
        {1'b1, 1'b0, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL cleared v=%b b=%b d=%0d l=%b exp 1 0 9 1", bus.deq_valid,
               bus.deq_blocked, bus.deq_data, bus.deq_lvl);
    end
    bus.rd_lvl = 1'b0;
    #1;
  endtask

  task automatic test_scrub();
    bus.scrub_lvl = 1'b0;
    bus.scrub_req = 1'b1;
    step();
    bus.scrub_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.scrub_busy, bus.scrub_done} !== {1'b1, (c == 4)}) begin
        errors++;
        $display("FAIL scrub_cyc%0d busy=%b done=%b exp 1/%b", c, bus.scrub_busy,
                 bus.scrub_done, (c == 4));
      end
      checks++;
      if ({bus.enq_ready, bus.deq_valid, bus.deq_blocked, bus.count} !==
          {1'b0, 1'b0, 1'b0, 3'd2}) begin
        errors++;
        $display("FAIL scrub_gate%0d er=%b dv=%b db=%b cnt=%0d exp 0 0 0 2", c,
                 bus.enq_ready, bus.deq_valid, bus.deq_blocked, bus.count);
      end
      step();
    end
    checks++;
    if ({bus.scrub_busy, bus.scrub_done, bus.deq_valid, bus.deq_data, bus.deq_lvl} !==
        {1'b0, 1'b0, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL post_scrub busy=%b done=%b dv=%b d=%0d l=%b exp 0 0 1 0 0",
               bus.scrub_busy, bus.scrub_done, bus.deq_valid, bus.deq_data, bus.deq_lvl);
    end
    bus.deq_ready = 1'b1;
    step();
    checks++;
    if ({bus.deq_valid, bus.deq_data, bus.deq_lvl, bus.count} !==
        {1'b1, 4'd5, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL second_head dv=%b d=%0d l=%b cnt=%0d exp 1 5 0 1", bus.deq_valid,
               bus.deq_data, bus.deq_lvl, bus.count);
    end
    step();
    bus.deq_ready = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL scrub_drain count=%0d exp 0", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    bus.enq_valid = 1'b1;
    bus.enq_data  = 4'd1;
    bus.enq_lvl   = 1'b0;
    step();
    for (int k = 2; k <= 6; k++) begin
      bus.enq_data  = 4'(k);
      bus.deq_ready = 1'b1;
      #1;
      checks++;
      if ({bus.deq_valid, bus.deq_data, bus.count} !== {1'b1, 4'(k - 1), 3'd1}) begin
        errors++;
        $display("FAIL wrap%0d dv=%b d=%0d cnt=%0d exp 1 %0d 1", k, bus.deq_valid,
                 bus.deq_data, bus.count, k - 1);
      end
      step();
    end
    bus.enq_valid = 1'b0;
    #1;
    checks++;
    if ({bus.deq_data, bus.count} !== {4'd6, 3'd1}) begin
      errors++;
      $display("FAIL wrap_last d=%0d cnt=%0d exp 6 1", bus.deq_data, bus.count);
    end
    step();
    bus.deq_ready = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_empty count=%0d exp 0", bus.count);
    end
  endtask

  task automatic test_scrub_with_enq();
    bus.rd_lvl    = 1'b0;
    bus.scrub_lvl = 1'b0;
    bus.scrub_req = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_data  = 4'd7;
    bus.enq_lvl   = 1'b1;
    #1;
    checks++;
    if (bus.enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL scrub_enq_ready got %b exp 1", bus.enq_ready);
    end
    step();
    bus.scrub_req = 1'b0;
    bus.enq_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.scrub_req = 1'b1;
        bus.scrub_lvl = 1'b1;
      end
      if (c == 3) bus.scrub_req = 1'b0;
      #1;
      checks++;
      if ({bus.scrub_busy, bus.scrub_done, bus.count} !== {1'b1, (c == 4), 3'd1}) begin
        errors++;
        $display("FAIL rescrub_cyc%0d busy=%b done=%b cnt=%0d exp 1 %b 1", c,
                 bus.scrub_busy, bus.scrub_done, bus.count, (c == 4));
      end
      step();
    end
    checks++;
    if ({bus.scrub_busy, bus.deq_valid, bus.deq_data, bus.deq_lvl} !==
        {1'b0, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL erased_entry busy=%b dv=%b d=%0d l=%b exp 0 1 0 0", bus.scrub_busy,
               bus.deq_valid, bus.deq_data, bus.deq_lvl);
    end
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scrub();
    bus.enq_valid = 1'b1;
    bus.enq_lvl   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.enq_data = 4'(10 + i);
      step();
    end
    bus.enq_valid = 1'b0;
    bus.scrub_req = 1'b1;
    bus.scrub_lvl = 1'b0;
    step();
    bus.scrub_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.count, bus.scrub_busy, bus.scrub_done, bus.enq_ready, bus.deq_valid} !==
        {3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort cnt=%0d busy=%b done=%b er=%b dv=%b exp 0 0 0 1 0",
               bus.count, bus.scrub_busy, bus.scrub_done, bus.enq_ready, bus.deq_valid);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if ({bus.scrub_busy, bus.scrub_done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_quiet%0d busy=%b done=%b exp 0 0", c, bus.scrub_busy,
                 bus.scrub_done);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_blocked_head();
    test_scrub();
    test_back_to_back();
    test_scrub_with_enq();
    test_reset_mid_scrub();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
